// File: rtl/axi_vip_slave_mem.sv
// AXI4 slave memory model with independent single-burst read and write engines.
// Optional build macro AXI_VIP_OOR_SLVERR_EN: out-of-range word index answers SLVERR instead of wrapping.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, storing beats until the beat counter reaches awlen
// W_RESP | bvalid high, waiting for bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, presenting beats until the rlast handshake
module axi_vip_slave_mem #(
  parameter int ID                = 0,
  parameter int MEM_SIZE          = 2**25,
  parameter int AXI_AXID_WIDTH    = 6,
  parameter int AXI_AXADDR_WIDTH  = 32,
  parameter int AXI_AXLEN_WIDTH   = 8,
  parameter int AXI_AXSIZE_WIDTH  = 3,
  parameter int AXI_AXBURST_WIDTH = 2,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_RESP_WIDTH    = 2
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AXI_AXID_WIDTH-1:0]    s_awid,
  input  logic [AXI_AXADDR_WIDTH-1:0]  s_awaddr,
  input  logic [AXI_AXLEN_WIDTH-1:0]   s_awlen,
  input  logic [AXI_AXSIZE_WIDTH-1:0]  s_awsize,
  input  logic [AXI_AXBURST_WIDTH-1:0] s_awburst,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]    s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]  s_wstrb,
  input  logic                         s_wlast,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [AXI_AXID_WIDTH-1:0]    s_bid,
  output logic [AXI_RESP_WIDTH-1:0]    s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [AXI_AXID_WIDTH-1:0]    s_arid,
  input  logic [AXI_AXADDR_WIDTH-1:0]  s_araddr,
  input  logic [AXI_AXLEN_WIDTH-1:0]   s_arlen,
  input  logic [AXI_AXSIZE_WIDTH-1:0]  s_arsize,
  input  logic [AXI_AXBURST_WIDTH-1:0] s_arburst,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [AXI_AXID_WIDTH-1:0]    s_rid,
  output logic [AXI_DATA_WIDTH-1:0]    s_rdata,
  output logic [AXI_RESP_WIDTH-1:0]    s_rresp,
  output logic                         s_rlast,
  output logic                         s_rvalid,
  input  logic                         s_rready
);
  localparam int AW    = AXI_AXADDR_WIDTH;
  localparam int LW    = AXI_AXLEN_WIDTH;
  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [7:0] mem_byte0 [MEM_SIZE];
  logic [7:0] mem_byte1 [MEM_SIZE];
  logic [7:0] mem_byte2 [MEM_SIZE];
  logic [7:0] mem_byte3 [MEM_SIZE];

  w_state_t                     w_state;
  r_state_t                     r_state;
  logic [AXI_AXID_WIDTH-1:0]    aw_id;
  logic [AW-1:0]                aw_addr, ar_addr, ar_next, r_src_addr;
  logic [LW-1:0]                aw_len, ar_len, w_cnt, r_cnt;
  logic [AXI_AXSIZE_WIDTH-1:0]  aw_size, ar_size;
  logic [AXI_AXBURST_WIDTH-1:0] aw_burst, ar_burst;
  logic                         w_err, w_oor, r_oor, w_hs;
  logic [IDX_W-1:0]             w_idx, r_idx;
  logic [AXI_DATA_WIDTH-1:0]    r_word;
  logic                         unused_ok;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [LW-1:0] len,
                                               input logic [AXI_AXSIZE_WIDTH-1:0] size,
                                               input logic [AXI_AXBURST_WIDTH-1:0] burst);
    logic [AW-1:0] step, blk;
    step = AW'(1) << size;
    blk  = step * (AW'(len) + AW'(1));
    case (burst)
      2'b00:   return a;
      // wrap block is (len+1)*step bytes, aligned to its own size
      2'b10:   return (a & ~(blk - AW'(1))) | ((a + step) & (blk - AW'(1)));
      default: return a + step;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
    return IDX_W'((a >> 2) % MEM_SIZE);
  endfunction

  assign w_hs       = s_wvalid && s_wready;
  assign w_idx      = word_idx(aw_addr);
  assign ar_next    = next_addr(ar_addr, ar_len, ar_size, ar_burst);
  assign r_src_addr = (r_state == R_IDLE) ? s_araddr : ar_next;
  assign r_idx      = word_idx(r_src_addr);
  assign r_word     = {mem_byte3[r_idx], mem_byte2[r_idx], mem_byte1[r_idx], mem_byte0[r_idx]};
  assign unused_ok  = s_wlast | (ID == 0);

`ifdef AXI_VIP_OOR_SLVERR_EN
  assign w_oor = {2'b00, aw_addr[AW-1:2]} >= AW'(MEM_SIZE);
  assign r_oor = {2'b00, r_src_addr[AW-1:2]} >= AW'(MEM_SIZE);
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  // storage is never reset
  always_ff @(posedge aclk) begin
    if (w_hs && !w_oor) begin
      if (s_wstrb[0]) mem_byte0[w_idx] <= s_wdata[7:0];
      if (s_wstrb[1]) mem_byte1[w_idx] <= s_wdata[15:8];
      if (s_wstrb[2]) mem_byte2[w_idx] <= s_wdata[23:16];
      if (s_wstrb[3]) mem_byte3[w_idx] <= s_wdata[31:24];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b1;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bid     <= '0;
      s_bresp   <= RESP_OKAY;
      aw_id     <= '0;
      aw_addr   <= '0;
      aw_len    <= '0;
      aw_size   <= '0;
      aw_burst  <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_awvalid && s_awready) begin
          aw_id     <= s_awid;
          aw_addr   <= s_awaddr;
          aw_len    <= s_awlen;
          aw_size   <= s_awsize;
          aw_burst  <= s_awburst;
          w_cnt     <= '0;
          w_err     <= 1'b0;
          s_awready <= 1'b0;
          s_wready  <= 1'b1;
          w_state   <= W_DATA;
        end
        W_DATA: if (w_hs) begin
`ifdef AXI_VIP_OOR_SLVERR_EN
          if (w_oor) $display("axi_vip_slave_mem[%0d]: write out of range at 0x%h", ID, aw_addr);
`endif
          w_err <= w_err | w_oor;
          if (w_cnt == aw_len) begin
            s_wready <= 1'b0;
            s_bvalid <= 1'b1;
            s_bid    <= aw_id;
            s_bresp  <= (w_err || w_oor) ? RESP_SLVERR : RESP_OKAY;
            w_state  <= W_RESP;
          end else begin
            w_cnt   <= w_cnt + LW'(1);
            aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
          end
        end
        W_RESP: if (s_bready) begin
          s_bvalid  <= 1'b0;
          s_awready <= 1'b1;
          w_state   <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rlast   <= 1'b0;
      s_rid     <= '0;
      s_rresp   <= RESP_OKAY;
      s_rdata   <= '0;
      ar_addr   <= '0;
      ar_len    <= '0;
      ar_size   <= '0;
      ar_burst  <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (s_arvalid && s_arready) begin
          ar_addr   <= s_araddr;
          ar_len    <= s_arlen;
          ar_size   <= s_arsize;
          ar_burst  <= s_arburst;
          r_cnt     <= '0;
          s_rid     <= s_arid;
          s_arready <= 1'b0;
          s_rvalid  <= 1'b1;
          s_rlast   <= (s_arlen == '0);
          s_rdata   <= r_oor ? '0 : r_word;
          s_rresp   <= r_oor ? RESP_SLVERR : RESP_OKAY;
          r_state   <= R_DATA;
        end
        R_DATA: if (s_rready) begin
          if (s_rlast) begin
            s_rvalid  <= 1'b0;
            s_rlast   <= 1'b0;
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end else begin
            ar_addr <= ar_next;
            r_cnt   <= r_cnt + LW'(1);
            s_rlast <= ((r_cnt + LW'(1)) == ar_len);
            s_rdata <= r_oor ? '0 : r_word;
            s_rresp <= r_oor ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
`ifdef AXI_VIP_OOR_SLVERR_EN
      if (r_oor && ((r_state == R_IDLE && s_arvalid) || (r_state == R_DATA && s_rready && !s_rlast)))
        $display("axi_vip_slave_mem[%0d]: read out of range at 0x%h", ID, r_src_addr);
`endif
    end
  end
endmodule

// File: tb/tb_axi_vip_slave_mem.sv
// Directed bench for axi_vip_slave_mem: single/INCR/WRAP/FIXED bursts, strobes, stalls, reset mid-burst.
module tb_axi_vip_slave_mem;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [5:0]  s_awid = '0, s_arid = '0, s_bid, s_rid;
  logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0, s_rdata;
  logic [7:0]  s_awlen = '0, s_arlen = '0;
  logic [2:0]  s_awsize = 3'd2, s_arsize = 3'd2;
  logic [1:0]  s_awburst = 2'b01, s_arburst = 2'b01, s_bresp, s_rresp;
  logic [3:0]  s_wstrb = '0;
  logic        s_awvalid = 0, s_awready, s_wlast = 0, s_wvalid = 0, s_wready;
  logic        s_bvalid, s_bready = 0, s_arvalid = 0, s_arready;
  logic        s_rlast, s_rvalid, s_rready = 1;

  int          n_chk = 0, n_err = 0;
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf_d [16];
  logic        rbuf_l [16];

  axi_vip_slave_mem #(.MEM_SIZE(4096)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    int t;
    @(negedge aclk);
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = 3'd2; s_awburst = burst; s_awvalid = 1;
    t = 0;
    while (!s_awready && t < 20) begin @(negedge aclk); t++; end
    if (!s_awready) check("aw_timeout", 0, 1);
    @(posedge aclk); #1 s_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wdata = wbuf[b]; s_wstrb = sbuf[b]; s_wlast = (b == int'(len)); s_wvalid = 1;
      @(negedge aclk);
      t = 0;
      while (!s_wready && t < 20) begin @(negedge aclk); t++; end
      if (!s_wready) check("w_timeout", 0, 1);
      @(posedge aclk); #1;
    end
    s_wvalid = 0; s_wlast = 0;
    check("bvalid_rise", 32'(s_bvalid), 1);
    check("bresp", 32'(s_bresp), 0);
    check("bid", 32'(s_bid), 32'(id));
    s_bready = 1;
    @(posedge aclk); #1 s_bready = 0;
    check("bvalid_drop", 32'(s_bvalid), 0);
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_b);
    int t;
    logic [31:0] d;
    logic l;
    s_rready = 1;
    @(negedge aclk);
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = 3'd2; s_arburst = burst; s_arvalid = 1;
    t = 0;
    while (!s_arready && t < 20) begin @(negedge aclk); t++; end
    if (!s_arready) check("ar_timeout", 0, 1);
    @(posedge aclk); #1 s_arvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge aclk);
      t = 0;
      while (!s_rvalid && t < 20) begin @(negedge aclk); t++; end
      if (!s_rvalid) check("r_timeout", 0, 1);
      check("rid", 32'(s_rid), 32'(id));
      d = s_rdata; l = s_rlast;
      if (b == stall_b) begin
        s_rready = 0;
        repeat (3) begin
          @(negedge aclk);
          check("stall_rdata", s_rdata, d);
          check("stall_rlast", 32'(s_rlast), 32'(l));
        end
        s_rready = 1;
      end
      rbuf_d[b] = d; rbuf_l[b] = l;
      @(posedge aclk); #1;
    end
    check("rvalid_drop", 32'(s_rvalid), 0);
    check("arready_back", 32'(s_arready), 1);
  endtask

  initial begin
    logic [31:0] exp_d [4];
    repeat (3) @(posedge aclk);
    @(negedge aclk) aresetn = 1;
    @(negedge aclk);
    check("rst_awready", 32'(s_awready), 1);
    check("rst_arready", 32'(s_arready), 1);
    check("rst_wready", 32'(s_wready), 0);
    check("rst_bvalid", 32'(s_bvalid), 0);
    check("rst_rvalid", 32'(s_rvalid), 0);
    check("rst_rdata", s_rdata, 0);

    // single beat full-word write
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(6'd0, 32'h100, 8'd0, 2'b01);
    check("mem_b3_40", 32'(dut.mem_byte3[12'h040]), 32'hDE);
    check("mem_b0_40", 32'(dut.mem_byte0[12'h040]), 32'hEF);

    // INCR len3 write, read back with a 3-cycle stall on beat 1
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    do_write(6'd5, 32'h200, 8'd3, 2'b01);
    do_read(6'd9, 32'h200, 8'd3, 2'b01, 1);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rbuf_d[i], 32'(i + 1));
      check("incr_rlast", 32'(rbuf_l[i]), (i == 3) ? 32'd1 : 32'd0);
    end

    // WRAP len3 from 0x208: words 0x208,0x20C,0x200,0x204
    exp_d[0] = 3; exp_d[1] = 4; exp_d[2] = 1; exp_d[3] = 2;
    do_read(6'd2, 32'h208, 8'd3, 2'b10, -1);
    for (int i = 0; i < 4; i++) begin
      check("wrap_rdata", rbuf_d[i], exp_d[i]);
      check("wrap_rlast", 32'(rbuf_l[i]), (i == 3) ? 32'd1 : 32'd0);
    end

    // FIXED len1 re-reads the same word
    do_read(6'd1, 32'h100, 8'd1, 2'b00, -1);
    check("fixed_b0", rbuf_d[0], 32'hDEADBEEF);
    check("fixed_b1", rbuf_d[1], 32'hDEADBEEF);
    check("fixed_last", 32'(rbuf_l[1]), 1);

    // strobe 0101 writes lanes 0 and 2 only
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(6'd3, 32'h300, 8'd0, 2'b01);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    do_write(6'd3, 32'h300, 8'd0, 2'b01);
    do_read(6'd4, 32'h300, 8'd0, 2'b01, -1);
    check("strb_rdata", rbuf_d[0], 32'h11BB33DD);
    check("strb_rlast", 32'(rbuf_l[0]), 1);

    // reset in the middle of a read burst
    @(negedge aclk);
    s_rready = 0; s_arid = 6'd7; s_araddr = 32'h200; s_arlen = 8'd3; s_arburst = 2'b01; s_arvalid = 1;
    @(posedge aclk); #1 s_arvalid = 0;
    check("mid_rvalid", 32'(s_rvalid), 1);
    #2 aresetn = 0;
    #1;
    check("mid_rst_rvalid", 32'(s_rvalid), 0);
    check("mid_rst_arready", 32'(s_arready), 1);
    @(negedge aclk) aresetn = 1;
    s_rready = 1;
    check("mem_kept", 32'(dut.mem_byte0[12'h080]), 32'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
